pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 29 ++
 rtl/pipeline_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the execution stage and the pipeline controller.
// master = execution/debug side, slave = controller.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             jump_en_i;
    logic [31:0]      jump_addr_i;
    logic             mc_req_i;
    logic             mc_done_i;
    logic             halt_req_i;
    logic             resume_i;
    logic             jump_en_o;
    logic [31:0]      jump_addr_o;
    logic             hold_o;
    logic             flush_o;
    logic             halted_o;
    logic             mc_err_o;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output jump_en_i, jump_addr_i, mc_req_i, mc_done_i, halt_req_i, resume_i,
        input  jump_en_o, jump_addr_o, hold_o, flush_o, halted_o, mc_err_o, stall_cnt
    );

    modport slave (
        input  jump_en_i, jump_addr_i, mc_req_i, mc_done_i, halt_req_i, resume_i,
        output jump_en_o, jump_addr_o, hold_o, flush_o, halted_o, mc_err_o, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: jump flush, multi-cycle stall with timeout abort,
// debug halt/resume and a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    pipeline_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, MC_WAIT, HALTED} state_e;

    localparam logic [15:0] TMO_LAST = 16'(MC_TIMEOUT - 1);

    state_e           state_q;
    logic             halt_pend_q;
    logic [15:0]      tmo_q;
    logic [15:0]      tmo_d;
    logic [CNT_W-1:0] stall_q;
    logic             halted_q;
    logic             mc_err_q;
    logic             jump_take;
    logic             hold;

    // Combinational outputs are gated by reset so they read 0 while it is asserted.
    always_comb begin
        jump_take = sys_rst_n && (state_q == RUN) && bus.jump_en_i;
        hold      = 1'b0;
        tmo_d     = tmo_q + 16'd1;
        if (sys_rst_n) begin
            case (state_q)
                RUN:     hold = bus.mc_req_i && !bus.jump_en_i;
                MC_WAIT: hold = !bus.mc_done_i;
                HALTED:  hold = 1'b1;
                default: hold = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= RUN;
            halt_pend_q <= 1'b0;
            tmo_q       <= '0;
            stall_q     <= '0;
            halted_q    <= 1'b0;
            mc_err_q    <= 1'b0;
        end else begin
            mc_err_q <= 1'b0;
            if (hold && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            case (state_q)
                RUN: begin
                    if (bus.jump_en_i) begin
                        if (bus.halt_req_i) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end
                    end else if (bus.mc_req_i) begin
                        state_q     <= MC_WAIT;
                        tmo_q       <= '0;
                        halt_pend_q <= bus.halt_req_i;
                    end else if (bus.halt_req_i) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                MC_WAIT: begin
                    tmo_q <= tmo_d;
                    // Timeout fires on the edge where the count would reach MC_TIMEOUT-1,
                    // so the total stall (including the request cycle) is MC_TIMEOUT.
                    if (bus.mc_done_i || (tmo_d == TMO_LAST)) begin
                        mc_err_q    <= !bus.mc_done_i;
                        halt_pend_q <= 1'b0;
                        if (halt_pend_q || bus.halt_req_i) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else if (bus.halt_req_i) begin
                        halt_pend_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (bus.resume_i) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.jump_en_o   = jump_take;
    assign bus.flush_o     = jump_take;
    assign bus.jump_addr_o = jump_take ? bus.jump_addr_i : 32'd0;
    assign bus.hold_o      = hold;
    assign bus.halted_o    = halted_q;
    assign bus.mc_err_o    = mc_err_q;
    assign bus.stall_cnt   = stall_q;
endmodule
